// File: rtl/ds_pkg.sv
// Shared types, control-word field positions and step-size helper for the
// multi-channel test-signal mixer.
package ds_pkg;

   typedef enum logic [1:0] {
      WM_OFF = 2'd0,
      WM_TRI = 2'd1,
      WM_SAW = 2'd2,
      WM_SQR = 2'd3
   } wave_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UPD  = 2'd1,
      ST_OUT  = 2'd2
   } mix_state_t;

   localparam int CTL_MODE_LSB = 14;
   localparam int MODE_BITS    = 2;
   localparam int CTL_AMP_LSB  = 8;
   localparam int AMP_BITS     = 4;
   localparam int CTL_OCT_LSB  = 4;

   // Alternating 0101..01 pattern of width-1 bits, scaled down by octave.
   function automatic logic [31:0] ds_delta(input int width, input int oct_bits,
                                            input int octave);
      logic [31:0] pat;
      pat = '0;
      for (int i = 0; i < width - 1; i += 2) pat[i] = 1'b1;
      return pat >> ((2 ** oct_bits - 1) - octave);
   endfunction

endpackage

// File: rtl/ds_wave_mixer_if.sv
// Configuration, step request and mix output bundle of ds_wave_mixer.
interface ds_wave_mixer_if #(
   parameter int WIDTH   = 16,
   parameter int CH_BITS = 2
);
   logic                     cfg_we;
   logic [CH_BITS-1:0]       cfg_ch;
   logic                     cfg_sel;
   logic [WIDTH-1:0]         cfg_data;
   logic                     step;
   logic [WIDTH+CH_BITS-1:0] u_out;
   logic                     u_valid;
   logic                     busy;
   logic                     overrun;

   modport master (
      output cfg_we, cfg_ch, cfg_sel, cfg_data, step,
      input  u_out, u_valid, busy, overrun
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_sel, cfg_data, step,
      output u_out, u_valid, busy, overrun
   );
endinterface

// File: rtl/ds_wave_channel_alu.sv
// Combinational per-channel update: next phase/direction and the channel's
// contribution to the mix, built around one add/subtract adder.
module ds_wave_channel_alu
   import ds_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0]    phase,
   input  logic                dir,
   input  wave_mode_t          mode,
   input  logic [WIDTH-1:0]    delta,
   input  logic [AMP_BITS-1:0] amp,
   input  logic                ovr,
   input  logic [WIDTH-1:0]    ovr_phase,
   output logic [WIDTH-1:0]    next_phase,
   output logic                next_dir,
   output logic [WIDTH-1:0]    contrib
);
   logic             sub;
   logic [WIDTH:0]   operand;
   logic [WIDTH:0]   s;
   logic [WIDTH-1:0] upd_phase;

   // Subtraction as add of the inverted operand plus carry-in; s[WIDTH] is carry or borrow.
   assign sub     = (mode == WM_TRI) && dir;
   assign operand = {1'b0, delta} ^ {(WIDTH + 1){sub}};
   assign s       = {1'b0, phase} + operand + (WIDTH + 1)'(sub);

   always_comb begin
      upd_phase = phase;
      next_dir  = dir;
      case (mode)
         WM_TRI: begin
            // Turn around on overflow, or once the walk has reached the outer quarter.
            if (!dir) begin
               if (s[WIDTH] || (phase[WIDTH-1 -: 2] == 2'b11)) next_dir = 1'b1;
               else                                             upd_phase = s[WIDTH-1:0];
            end else begin
               if (s[WIDTH] || (phase[WIDTH-1 -: 2] == 2'b00)) next_dir = 1'b0;
               else                                             upd_phase = s[WIDTH-1:0];
            end
         end
         WM_SAW, WM_SQR: upd_phase = s[WIDTH-1:0];
         default:        upd_phase = phase;
      endcase

      next_phase = ovr ? ovr_phase : upd_phase;

      case (mode)
         WM_TRI, WM_SAW: contrib = next_phase >> amp;
         WM_SQR:         contrib = next_phase[WIDTH-1] ? ({WIDTH{1'b1}} >> amp) : '0;
         default:        contrib = '0;
      endcase
   end
endmodule

// File: rtl/ds_wave_mixer.sv
// Multi-channel test-signal source for the modulator input: channels are
// stepped one per cycle through a shared ALU and their sum is registered out.
module ds_wave_mixer
   import ds_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int WIDTH    = 16,
   parameter int OCT_BITS = 4,
   parameter int CH_BITS  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic            clk,
   input  logic            reset,
   ds_wave_mixer_if.slave  bus
);
   localparam int                 SUM_W   = WIDTH + CH_BITS;
   localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CH - 1);

   mix_state_t          state, state_nxt;
   logic [CH_BITS-1:0]  ch_q;
   logic [WIDTH-1:0]    phase_q [NUM_CH];
   logic                dir_q   [NUM_CH];
   wave_mode_t          mode_q  [NUM_CH];
   logic [AMP_BITS-1:0] amp_q   [NUM_CH];
   logic [OCT_BITS-1:0] oct_q   [NUM_CH];
   logic [SUM_W-1:0]    acc_q;
   logic [SUM_W-1:0]    u_out_q;
   logic                u_valid_q;
   logic                pending_q;
   logic                overrun_q;

   logic                cfg_hit;
   logic                ovr;
   logic [WIDTH-1:0]    delta;
   logic [WIDTH-1:0]    alu_phase;
   logic                alu_dir;
   logic [WIDTH-1:0]    alu_contrib;
   logic                unused_cfg_bits;

   assign cfg_hit         = bus.cfg_we && (int'(bus.cfg_ch) < NUM_CH);
   assign ovr             = (state == ST_UPD) && cfg_hit && !bus.cfg_sel && (bus.cfg_ch == ch_q);
   assign delta           = WIDTH'(ds_delta(WIDTH, OCT_BITS, int'(oct_q[ch_q])));
   assign unused_cfg_bits = ^bus.cfg_data;

   assign bus.u_out   = u_out_q;
   assign bus.u_valid = u_valid_q;
   assign bus.overrun = overrun_q;

   ds_wave_channel_alu #(.WIDTH(WIDTH)) u_alu (
      .phase      (phase_q[ch_q]),
      .dir        (dir_q[ch_q]),
      .mode       (mode_q[ch_q]),
      .delta      (delta),
      .amp        (amp_q[ch_q]),
      .ovr        (ovr),
      .ovr_phase  (bus.cfg_data),
      .next_phase (alu_phase),
      .next_dir   (alu_dir),
      .contrib    (alu_contrib)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      bus.busy  = (state != ST_IDLE);
      case (state)
         ST_IDLE: if (bus.step || pending_q) state_nxt = ST_UPD;
         ST_UPD:  if (ch_q == LAST_CH)       state_nxt = ST_OUT;
         ST_OUT:                             state_nxt = ST_IDLE;
         default:                            state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ch_q      <= '0;
         acc_q     <= '0;
         u_out_q   <= '0;
         u_valid_q <= 1'b0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            phase_q[i] <= {1'b1, {(WIDTH - 1){1'b0}}};
            dir_q[i]   <= 1'b0;
            mode_q[i]  <= WM_OFF;
            amp_q[i]   <= '0;
            oct_q[i]   <= '0;
         end
      end else begin
         u_valid_q <= 1'b0;
         case (state)
            ST_UPD: begin
               phase_q[ch_q] <= alu_phase;
               dir_q[ch_q]   <= alu_dir;
               acc_q         <= ((ch_q == '0) ? '0 : acc_q) + SUM_W'(alu_contrib);
               ch_q          <= (ch_q == LAST_CH) ? '0 : ch_q + CH_BITS'(1);
            end
            ST_OUT: begin
               u_out_q   <= acc_q;
               u_valid_q <= 1'b1;
            end
            default: ch_q <= '0;
         endcase

         // One request may wait behind a running sequence; any further one is lost.
         if (state == ST_IDLE) begin
            pending_q <= pending_q && bus.step;
         end else if (bus.step) begin
            if (pending_q) overrun_q <= 1'b1;
            else           pending_q <= 1'b1;
         end

         // Placed last so a phase write overrides the update of the same channel.
         if (cfg_hit) begin
            if (!bus.cfg_sel) begin
               phase_q[bus.cfg_ch] <= bus.cfg_data;
               dir_q[bus.cfg_ch]   <= 1'b0;
            end else begin
               mode_q[bus.cfg_ch] <= wave_mode_t'(bus.cfg_data[CTL_MODE_LSB +: MODE_BITS]);
               amp_q[bus.cfg_ch]  <= bus.cfg_data[CTL_AMP_LSB +: AMP_BITS];
               oct_q[bus.cfg_ch]  <= bus.cfg_data[CTL_OCT_LSB +: OCT_BITS];
            end
         end
      end
   end
endmodule

// File: tb/tb_ds_wave_mixer.sv
// Scoreboard bench for ds_wave_mixer: expected mix values and arrival cycles
// are queued when a step is driven and checked when u_valid pulses.
module tb_ds_wave_mixer;
   localparam int NUM_CH   = 4;
   localparam int WIDTH    = 16;
   localparam int OCT_BITS = 4;
   localparam int CH_BITS  = 2;
   localparam int SUM_W    = WIDTH + CH_BITS;

   typedef struct {
      logic [SUM_W-1:0] val;
      int               cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ds_wave_mixer_if #(.WIDTH(WIDTH), .CH_BITS(CH_BITS)) bus();

   ds_wave_mixer #(
      .NUM_CH(NUM_CH), .WIDTH(WIDTH), .OCT_BITS(OCT_BITS), .CH_BITS(CH_BITS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Output monitor: every u_valid must match the oldest queued expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus.u_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("u_out", 32'(bus.u_out), 32'(e.val));
            check("latency", cyc, e.cyc);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #2;
      check("rst_u_out", 32'(bus.u_out), 32'd0);
      check("rst_u_valid", 32'(bus.u_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_overrun", 32'(bus.overrun), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
   endtask

   task automatic cfg(input int ch, input logic sel, input logic [15:0] d);
      bus.cfg_we   = 1'b1;
      bus.cfg_ch   = CH_BITS'(ch);
      bus.cfg_sel  = sel;
      bus.cfg_data = d;
      @(negedge clk);
      bus.cfg_we   = 1'b0;
   endtask

   task automatic push_step(input logic [SUM_W-1:0] v);
      bus.step = 1'b1;
      sb.push_back('{v, cyc + 6});
      @(negedge clk);
      bus.step = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", sb.size(), 0);
      sb.delete();
   endtask

   task automatic step_exp(input logic [SUM_W-1:0] v);
      push_step(v);
      drain();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int t;
      reset        = 1'b1;
      bus.cfg_we   = 1'b0;
      bus.cfg_ch   = '0;
      bus.cfg_sel  = 1'b0;
      bus.cfg_data = '0;
      bus.step     = 1'b0;

      // All channels off: zero mix, six-cycle latency, busy window.
      do_reset();
      bus.step = 1'b1;
      sb.push_back('{'0, cyc + 6});
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         bus.step = 1'b0;
         check($sformatf("busy_t%0d", k), 32'(bus.busy), (k <= 5) ? 32'd1 : 32'd0);
      end
      drain();

      // Triangle on ch0 at full step size, including both turnarounds.
      do_reset();
      cfg(0, 1'b1, 16'h40F0);
      step_exp(18'h0D555);
      step_exp(18'h0D555);
      step_exp(18'h08000);
      step_exp(18'h02AAB);
      step_exp(18'h02AAB);
      step_exp(18'h08000);

      // Sawtooth on ch1 wrapping past the top.
      do_reset();
      cfg(1, 1'b0, 16'hFFF0);
      cfg(1, 1'b1, 16'h80F0);
      step_exp(18'h05545);
      step_exp(18'h0AA9A);

      // Four squares with zero step: amplitude shift 2, then 0 (full-scale sum).
      do_reset();
      for (int c = 0; c < NUM_CH; c++) cfg(c, 1'b1, 16'hC200);
      step_exp(18'h0FFFC);
      for (int c = 0; c < NUM_CH; c++) cfg(c, 1'b1, 16'hC000);
      step_exp(18'h3FFFC);

      // Three back-to-back steps: one pending, one dropped.
      do_reset();
      cfg(0, 1'b1, 16'h8000);
      t = cyc;
      bus.step = 1'b1;
      sb.push_back('{18'h08000, t + 6});
      sb.push_back('{18'h08000, t + 12});
      @(negedge clk);
      check("overrun_t1", 32'(bus.overrun), 32'd0);
      @(negedge clk);
      check("overrun_t2", 32'(bus.overrun), 32'd0);
      @(negedge clk);
      bus.step = 1'b0;
      check("overrun_t3", 32'(bus.overrun), 32'd1);
      drain();
      repeat (3) @(negedge clk);
      check("overrun_sticky", 32'(bus.overrun), 32'd1);
      check("idle_after_pending", 32'(bus.busy), 32'd0);

      // Reset in the middle of a sequence (during the ch2 update).
      do_reset();
      cfg(0, 1'b1, 16'h80F0);
      step_exp(18'h0D555);
      step_exp(18'h02AAA);
      bus.step = 1'b1;
      @(negedge clk);
      bus.step = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midseq_busy", 32'(bus.busy), 32'd0);
      check("midseq_valid", 32'(bus.u_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      check("midseq_overrun", 32'(bus.overrun), 32'd0);
      cfg(0, 1'b1, 16'h8000);
      cfg(2, 1'b1, 16'h8000);
      step_exp(18'h10000);

      // Phase write landing on ch1 while ch1 is being updated.
      do_reset();
      cfg(1, 1'b1, 16'h80F0);
      bus.step = 1'b1;
      sb.push_back('{18'h01234, cyc + 6});
      @(negedge clk);
      bus.step = 1'b0;
      @(negedge clk);
      cfg(1, 1'b0, 16'h1234);
      drain();
      step_exp(18'h06789);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
